multicycle_control: RTL

//  Multi-cycle sequencer for the CPU core. Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.

---
 rtl/multicycle_control_if.sv | 10 +
 rtl/multicycle_control.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_if.sv
// Data-memory handshake between the multi-cycle sequencer (master) and a
// variable-latency data memory (slave).
interface multicycle_control_if;
  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (output mem_req, output mem_we, input mem_ready);
  modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with a data-memory
// handshake, timeout-to-halt, and a retired-instruction counter.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 run,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 zero,
  multicycle_control_if.master mem,
  output logic                 ir_we,
  output logic                 write_pc,
  output logic                 is_branch,
  output logic                 is_jump,
  output logic                 is_jr,
  output logic                 reg_we,
  output logic [1:0]           reg_dst,
  output logic [1:0]           wb_sel,
  output logic                 alu_src,
  output logic [2:0]           alu_op,
  output logic                 halted,
  output logic                 mem_error,
  output logic [CNT_W-1:0]     instr_count
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;

  localparam int TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  state_t           state;
  state_t           next_state;
  logic [TMO_W-1:0] tmo_cnt;
  logic             mem_error_q;
  logic             set_mem_error;

  logic op_rtype, op_j, op_jal, op_jr, op_lw, op_sw;
  logic op_beq, op_bne, op_addi, op_xori, rtype_alu, to_exec;

  assign op_rtype  = (opcode == 6'h00);
  assign op_j      = (opcode == 6'h02);
  assign op_jal    = (opcode == 6'h03);
  assign op_beq    = (opcode == 6'h04);
  assign op_bne    = (opcode == 6'h05);
  assign op_addi   = (opcode == 6'h08);
  assign op_xori   = (opcode == 6'h0E);
  assign op_lw     = (opcode == 6'h23);
  assign op_sw     = (opcode == 6'h2B);
  assign op_jr     = op_rtype && (funct == 6'h08);
  assign rtype_alu = op_rtype && ((funct == 6'h20) || (funct == 6'h22) || (funct == 6'h2A));
  assign to_exec   = rtype_alu || op_lw || op_sw || op_beq || op_bne || op_addi || op_xori;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= FETCH;
      tmo_cnt     <= '0;
      mem_error_q <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= next_state;
      if (set_mem_error) mem_error_q <= 1'b1;
      if (state != MEM) begin
        tmo_cnt <= '0;
      end else if (!mem.mem_ready && (tmo_cnt != TMO_LAST)) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
      // write_pc marks the final cycle of every instruction, so it doubles as the retire strobe.
      if (write_pc) instr_count <= instr_count + CNT_W'(1);
    end
  end

  always_comb begin
    next_state    = state;
    set_mem_error = 1'b0;
    ir_we         = 1'b0;
    write_pc      = 1'b0;
    is_branch     = 1'b0;
    is_jump       = 1'b0;
    is_jr         = 1'b0;
    reg_we        = 1'b0;
    reg_dst       = 2'd0;
    wb_sel        = 2'd0;
    alu_src       = 1'b0;
    alu_op        = ALU_ADD;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    halted        = 1'b0;
    mem_error     = 1'b0;

    case (state)
      FETCH: begin
        if (run) begin
          ir_we      = 1'b1;
          next_state = DECODE;
        end
      end
      DECODE: begin
        if (op_j || op_jal) begin
          write_pc   = 1'b1;
          is_jump    = 1'b1;
          next_state = FETCH;
          if (op_jal) begin
            reg_we  = 1'b1;
            reg_dst = 2'd2;
            wb_sel  = 2'd2;
          end
        end else if (op_jr) begin
          write_pc   = 1'b1;
          is_jr      = 1'b1;
          next_state = FETCH;
        end else if (to_exec) begin
          next_state = EXEC;
        end else begin
          next_state = HALT;
        end
      end
      EXEC: begin
        if (op_rtype) begin
          case (funct)
            6'h22:   alu_op = ALU_SUB;
            6'h2A:   alu_op = ALU_SLT;
            default: alu_op = ALU_ADD;
          endcase
          next_state = WB;
        end else if (op_beq || op_bne) begin
          alu_op     = ALU_SUB;
          write_pc   = 1'b1;
          is_branch  = (op_beq && zero) || (op_bne && !zero);
          next_state = FETCH;
        end else begin
          alu_src    = 1'b1;
          alu_op     = op_xori ? ALU_XOR : ALU_ADD;
          next_state = (op_lw || op_sw) ? MEM : WB;
        end
      end
      MEM: begin
        mem.mem_req = 1'b1;
        mem.mem_we  = op_sw;
        if (mem.mem_ready) begin
          if (op_sw) begin
            write_pc   = 1'b1;
            next_state = FETCH;
          end else begin
            next_state = WB;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          set_mem_error = 1'b1;
          next_state    = HALT;
        end
      end
      WB: begin
        reg_we     = 1'b1;
        write_pc   = 1'b1;
        reg_dst    = op_rtype ? 2'd1 : 2'd0;
        wb_sel     = op_lw ? 2'd1 : 2'd0;
        next_state = FETCH;
      end
      HALT: begin
        halted    = 1'b1;
        mem_error = mem_error_q;
      end
      default: next_state = FETCH;
    endcase

    // Reset must silence every strobe at once, including the Mealy ir_we in FETCH.
    if (!reset_n) begin
      ir_we       = 1'b0;
      write_pc    = 1'b0;
      is_branch   = 1'b0;
      is_jump     = 1'b0;
      is_jr       = 1'b0;
      reg_we      = 1'b0;
      reg_dst     = 2'd0;
      wb_sel      = 2'd0;
      alu_src     = 1'b0;
      alu_op      = ALU_ADD;
      mem.mem_req = 1'b0;
      mem.mem_we  = 1'b0;
      halted      = 1'b0;
      mem_error   = 1'b0;
    end
  end

endmodule
